mesi_bus_controller: RTL and testbench
======================================

// Module: mesi_bus_controller
// PURPOSE
//  Shared-bus sequencer downstream of the per-cache MESI emitter. Accepts one bus request at a time (msg rh/rm/wh/wm + wb flag)
//  from any cache, runs the writeback, broadcast/snoop and memory-fetch phases, and returns the shared flag to the requester.
//  The shared flag feeds the emitter's I-state rm decision (S vs E). Snooping caches observe the broadcast phase.
// PARAMETERS
//  ADDR_W   8  line address width
//  N_CACHE  4  number of caches on the bus; N_CACHE <= 2**ID_W
//  ID_W     2  requester id width
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  req_valid  in   1        request present
//  req_ready  out  1        controller idle, can accept
//  req_msg    in   2        00 rh, 01 rm, 10 wh, 11 wm
//  req_wb     in   1        evicted line must be written back first
//  req_addr   in   ADDR_W   line address
//  req_id     in   ID_W     requesting cache
//  bus_valid  out  1        broadcast phase active
//  bus_msg    out  2        captured msg during broadcast
//  bus_addr   out  ADDR_W   captured address during broadcast
//  bus_src    out  ID_W     captured id during broadcast
//  snp_hit    in   N_CACHE  per-cache "line present" response, valid while bus_valid
//  mem_rd     out  1        memory line fetch request
//  mem_wr     out  1        memory writeback request
//  mem_addr   out  ADDR_W   address for mem_rd/mem_wr
//  mem_ack    in   1        memory completed current request
//  done       out  1        one-cycle completion pulse
//  shared     out  1        another cache held the line (valid with done)
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; req_ready=1; bus_valid, mem_rd, mem_wr, done, shared=0; bus_*/mem_addr=0;
//    in-flight transaction discarded, no partial completion.
//  - States: IDLE, WB, BCAST, MEM, DONE. Request captured at edge with req_valid & req_ready (msg, wb, addr, id registered).
//  - req_ready=1 only in IDLE; all other inputs except snp_hit/mem_ack ignored outside IDLE.
//  - IDLE: rh or wh -> DONE (no bus or memory activity; req_wb ignored). rm/wm: wb=1 -> WB, else -> BCAST.
//  - WB: mem_wr=1, mem_addr=captured addr; hold until mem_ack=1 sampled, then -> BCAST. mem_wr low next cycle.
//  - BCAST: exactly one cycle; bus_valid=1 with bus_msg/addr/src. Register shared=|(snp_hit & ~(1<<src)).
//    Requester's own snp_hit bit always masked. wm broadcast = invalidate for snoopers. -> MEM.
//  - MEM: mem_rd=1, mem_addr=captured addr; hold until mem_ack=1, then -> DONE.
//  - DONE: done=1 for one cycle -> IDLE. New request accepted no earlier than the IDLE cycle after DONE.
//  - shared: updated only in BCAST; for rh/wh forced 0 at capture; held stable from update until next capture.
//  - mem_ack outside WB/MEM ignored; mem_ack in same cycle request is first raised completes it (zero-wait memory).
//  - mem_rd and mem_wr never both high. bus_valid never high outside BCAST.
//  - Latency (zero-wait memory): rh/wh done 1 cycle after accept; rm/wm no wb 3 cycles; rm/wm with wb 4 cycles.
//  - No timeout: controller waits indefinitely for mem_ack.
// TESTING
//  - Reset: rst_n=0 mid-MEM -> immediately req_ready=1, mem_rd=0, done=0, shared=0; next request accepted normally.
//  - rh, id=1, addr=8'h10 -> done 1 cycle later, shared=0, bus_valid/mem_rd/mem_wr never asserted.
//  - rm, id=0, addr=8'h22, wb=0, snp_hit=4'b0100, ack immediate -> bus_valid 1 cycle (msg=01, src=0),
//    mem_rd for addr 8'h22, done 3 cycles after accept with shared=1.
//  - rm, id=2, snp_hit=4'b0100 (only own bit) -> shared=0 at done.
//  - wm, id=3, addr=8'hF0, wb=1, mem_ack delayed 2 cycles each phase -> mem_wr 3 cycles, bcast (msg=11),
//    mem_rd 3 cycles, done 8 cycles after accept; mem_rd/mem_wr never overlap.
//  - Back-to-back: req_valid held with new request during DONE -> not accepted until IDLE; stray mem_ack in IDLE ignored.

Source files
------------

// File: rtl/mesi_bus_controller.sv
// mesi_bus_controller: shared-bus sequencer for MESI cache misses.
// Runs writeback, broadcast/snoop and memory fetch, returns shared flag.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/ready     one request at a time, accepted in IDLE
//   req_msg/wb/addr/id  00 rh, 01 rm, 10 wh, 11 wm; wb = writeback first
//   bus_valid/msg/...   one-cycle broadcast of the captured request
//   snp_hit             per-cache line-present, sampled during broadcast
//   mem_rd/wr/addr/ack  memory fetch / writeback handshake
//   done, shared        completion pulse, another cache held the line
module mesi_bus_controller #(
  parameter int ADDR_W  = 8,
  parameter int N_CACHE = 4,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_msg,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  output logic              bus_valid,
  output logic [1:0]        bus_msg,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [ID_W-1:0]   bus_src,
  input  logic [N_CACHE-1:0] snp_hit,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              done,
  output logic              shared
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_BCAST,
    S_MEM,
    S_DONE
  } state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                bus_valid_q;
  logic [1:0]          bus_msg_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [ID_W-1:0]     bus_src_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                done_q;
  logic                shared_q;

  logic [N_CACHE-1:0]  own_mask;
  logic                snoop_any;

  // The requester always answers its own snoop; mask it out.
  always_comb begin
    own_mask  = N_CACHE'(1) << bus_src_q;
    snoop_any = |(snp_hit & ~own_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      bus_valid_q <= 1'b0;
      bus_msg_q   <= '0;
      bus_addr_q  <= '0;
      bus_src_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
      shared_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            bus_msg_q   <= req_msg;
            bus_addr_q  <= req_addr;
            bus_src_q   <= req_id;
            mem_addr_q  <= req_addr;
            // msg bit 0 set = miss (rm/wm); hits finish locally.
            if (!req_msg[0]) begin
              shared_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (req_wb) begin
              mem_wr_q <= 1'b1;
              state_q  <= S_WB;
            end else begin
              bus_valid_q <= 1'b1;
              state_q     <= S_BCAST;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            mem_wr_q    <= 1'b0;
            bus_valid_q <= 1'b1;
            state_q     <= S_BCAST;
          end
        end
        S_BCAST: begin
          bus_valid_q <= 1'b0;
          shared_q    <= snoop_any;
          mem_rd_q    <= 1'b1;
          state_q     <= S_MEM;
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_rd_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign bus_valid = bus_valid_q;
  assign bus_msg   = bus_msg_q;
  assign bus_addr  = bus_addr_q;
  assign bus_src   = bus_src_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign done      = done_q;
  assign shared    = shared_q;

endmodule

// File: tb/tb_mesi_bus_controller.sv
// tb_mesi_bus_controller: directed bench for mesi_bus_controller.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_mesi_bus_controller;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_msg;
  logic       req_wb;
  logic [7:0] req_addr;
  logic [1:0] req_id;
  logic       bus_valid;
  logic [1:0] bus_msg;
  logic [7:0] bus_addr;
  logic [1:0] bus_src;
  logic [3:0] snp_hit;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic       done;
  logic       shared;

  int total;
  int bad;

  mesi_bus_controller #(
    .ADDR_W (8),
    .N_CACHE(4),
    .ID_W   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_msg  (req_msg),
    .req_wb   (req_wb),
    .req_addr (req_addr),
    .req_id   (req_id),
    .bus_valid(bus_valid),
    .bus_msg  (bus_msg),
    .bus_addr (bus_addr),
    .bus_src  (bus_src),
    .snp_hit  (snp_hit),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .done     (done),
    .shared   (shared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] m, input logic wb,
                     input logic [7:0] a, input logic [1:0] id);
    req_valid = 1'b1;
    req_msg   = m;
    req_wb    = wb;
    req_addr  = a;
    req_id    = id;
  endtask

  // Expected per-cycle outputs for the delayed-ack wm with writeback.
  logic exp_wr [1:8];
  logic exp_rd [1:8];
  logic exp_bv [1:8];
  logic exp_dn [1:8];

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_msg   = 2'b00;
    req_wb    = 1'b0;
    req_addr  = 8'h00;
    req_id    = 2'b00;
    snp_hit   = 4'b0000;
    mem_ack   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_wr[c] = (c <= 3);
      exp_bv[c] = (c == 4);
      exp_rd[c] = (c >= 5 && c <= 7);
      exp_dn[c] = (c == 8);
    end

    step();
    step();
    chk("rst_ready", 8'(req_ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_shared", 8'(shared), 8'd0);
    chk("rst_bus_valid", 8'(bus_valid), 8'd0);
    chk("rst_mem", {6'd0, mem_rd, mem_wr}, 8'd0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    rst_n = 1'b1;
    step();

    // rh hit: done next cycle, no bus/memory activity.
    req(2'b00, 1'b1, 8'h10, 2'd1);
    step();
    req_valid = 1'b0;
    chk("rh_done", 8'(done), 8'd1);
    chk("rh_shared", 8'(shared), 8'd0);
    chk("rh_quiet", {5'd0, bus_valid, mem_rd, mem_wr}, 8'd0);
    chk("rh_ready", 8'(req_ready), 8'd0);
    step();
    chk("rh_idle_ready", 8'(req_ready), 8'd1);
    chk("rh_idle_done", 8'(done), 8'd0);

    // rm, no wb, other cache holds line, zero-wait memory.
    req(2'b01, 1'b0, 8'h22, 2'd0);
    snp_hit = 4'b0100;
    step();
    req_valid = 1'b0;
    chk("rm1_bv", 8'(bus_valid), 8'd1);
    chk("rm1_msg", 8'(bus_msg), 8'h01);
    chk("rm1_src", 8'(bus_src), 8'h00);
    chk("rm1_addr", bus_addr, 8'h22);
    chk("rm1_nomem", {6'd0, mem_rd, mem_wr}, 8'd0);
    step();
    mem_ack = 1'b1;
    chk("rm1_bv_off", 8'(bus_valid), 8'd0);
    chk("rm1_rd", 8'(mem_rd), 8'd1);
    chk("rm1_maddr", mem_addr, 8'h22);
    step();
    mem_ack = 1'b0;
    chk("rm1_done", 8'(done), 8'd1);
    chk("rm1_shared", 8'(shared), 8'd1);
    chk("rm1_rd_off", 8'(mem_rd), 8'd0);
    step();

    // rm from cache 2; only its own snoop bit set -> not shared.
    req(2'b01, 1'b0, 8'h23, 2'd2);
    snp_hit = 4'b0100;
    step();
    req_valid = 1'b0;
    chk("rm2_bv", 8'(bus_valid), 8'd1);
    chk("rm2_src", 8'(bus_src), 8'h02);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rm2_done", 8'(done), 8'd1);
    chk("rm2_shared", 8'(shared), 8'd0);
    step();

    // wm with writeback, each memory phase acks on its third cycle.
    req(2'b11, 1'b1, 8'hF0, 2'd3);
    snp_hit = 4'b0011;
    for (int c = 1; c <= 8; c++) begin
      step();
      req_valid = 1'b0;
      mem_ack   = (c == 3) || (c == 7);
      chk($sformatf("wm_wr_c%0d", c), 8'(mem_wr), 8'(exp_wr[c]));
      chk($sformatf("wm_rd_c%0d", c), 8'(mem_rd), 8'(exp_rd[c]));
      chk($sformatf("wm_bv_c%0d", c), 8'(bus_valid), 8'(exp_bv[c]));
      chk($sformatf("wm_dn_c%0d", c), 8'(done), 8'(exp_dn[c]));
      chk($sformatf("wm_excl_c%0d", c), 8'(mem_rd & mem_wr), 8'd0);
      if (c == 1) chk("wm_maddr_wr", mem_addr, 8'hF0);
      if (c == 4) chk("wm_msg", 8'(bus_msg), 8'h03);
      if (c == 4) chk("wm_addr", bus_addr, 8'hF0);
      if (c == 8) chk("wm_shared", 8'(shared), 8'd1);
    end
    mem_ack = 1'b0;
    step();

    // Back-to-back: rh, then new rm held during DONE; stray ack in IDLE.
    req(2'b10, 1'b0, 8'h11, 2'd0);
    step();
    chk("b2b_done", 8'(done), 8'd1);
    chk("b2b_wh_shared", 8'(shared), 8'd0);
    chk("b2b_busy", 8'(req_ready), 8'd0);
    req(2'b01, 1'b0, 8'h33, 2'd1);
    snp_hit = 4'b0010;
    step();
    mem_ack = 1'b1;
    chk("b2b_idle_ready", 8'(req_ready), 8'd1);
    chk("b2b_not_taken", 8'(bus_valid), 8'd0);
    step();
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    chk("b2b_bv", 8'(bus_valid), 8'd1);
    chk("b2b_addr", bus_addr, 8'h33);
    step();
    chk("b2b_rd", 8'(mem_rd), 8'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("b2b_rm_done", 8'(done), 8'd1);
    chk("b2b_rm_shared", 8'(shared), 8'd0);
    step();

    // Reset while waiting in MEM with shared already set.
    req(2'b01, 1'b0, 8'h44, 2'd0);
    snp_hit = 4'b0100;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rstm_rd", 8'(mem_rd), 8'd1);
    chk("rstm_shared_pre", 8'(shared), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_ready", 8'(req_ready), 8'd1);
    chk("rstm_rd_off", 8'(mem_rd), 8'd0);
    chk("rstm_done", 8'(done), 8'd0);
    chk("rstm_shared", 8'(shared), 8'd0);
    step();
    rst_n = 1'b1;
    step();
    req(2'b00, 1'b0, 8'h55, 2'd2);
    step();
    req_valid = 1'b0;
    chk("post_rst_done", 8'(done), 8'd1);
    step();
    chk("post_rst_ready", 8'(req_ready), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
